// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: three-stage pipelined Dadda-tree multiplier, N x N -> 2N.
// Per-operation signed (Baugh-Wooley) or unsigned mode, valid/ready on both
// sides, and a pass-through tag. One global advance signal moves all stages
// together, so a stalled pipe simply holds its occupied stages.
module dadda_mul_pipe #(
  parameter int N    = 8,
  parameter int TAGW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic              sgn,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    y,
  output logic [TAGW-1:0]   out_tag
);

  // Reduce the partial-product matrix (bit i*N+j has weight i+j) plus the
  // Baugh-Wooley constants (present only when bw=1) to two 2N-bit rows using
  // the Dadda height sequence 2,3,4,6,9,13,... Returns {row1, row0}.
  // Column heights depend only on N, so every loop unrolls to fixed wiring.
  function automatic logic [4*N-1:0] dadda_reduce(input logic [N*N-1:0] pp,
                                                  input logic           bw);
    logic           m   [2*N][N+2];
    logic           nm  [2*N][N+2];
    int             h   [2*N];
    int             nh  [2*N];
    int             seq [16];
    int             ns;
    int             maxh;
    int             p;
    int             d;
    int             rem;
    logic [2*N-1:0] r0;
    logic [2*N-1:0] r1;
    for (int c = 0; c < 2*N; c++) begin
      h[c]  = 0;
      nh[c] = 0;
      for (int k = 0; k < N+2; k++) begin
        m[c][k]  = 1'b0;
        nm[c][k] = 1'b0;
      end
    end
    for (int k = 0; k < 16; k++) seq[k] = 0;
    r0 = '0;
    r1 = '0;
    // Load partial products into their weight columns
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        m[i+j][h[i+j]] = pp[i*N+j];
        h[i+j] = h[i+j] + 1;
      end
    end
    // Baugh-Wooley correction ones at columns N and 2N-1 (zero in unsigned mode)
    m[N][h[N]] = bw;
    h[N] = h[N] + 1;
    m[2*N-1][h[2*N-1]] = bw;
    h[2*N-1] = h[2*N-1] + 1;
    maxh = 0;
    for (int c = 0; c < 2*N; c++) begin
      if (h[c] > maxh) maxh = h[c];
    end
    // Dadda targets strictly below the initial maximum height
    seq[0] = 2;
    ns = 1;
    for (int k = 1; k < 16; k++) begin
      if ((ns == k) && ((seq[k-1] * 3) / 2 < maxh)) begin
        seq[k] = (seq[k-1] * 3) / 2;
        ns = k + 1;
      end
    end
    for (int s = 15; s >= 0; s--) begin
      if (s < ns) begin
        d = seq[s];
        for (int c = 0; c < 2*N; c++) begin
          nh[c] = 0;
          for (int k = 0; k < N+2; k++) nm[c][k] = 1'b0;
        end
        // Columns low to high: carries from column c land in nm[c+1] first,
        // so the effective height counts them before c+1 is reduced.
        for (int c = 0; c < 2*N; c++) begin
          p = 0;
          for (int it = 0; it <= N; it++) begin
            rem = h[c] - p;
            if (rem + nh[c] > d) begin
              if (((rem + nh[c] == d + 1) || (rem == 2)) && (rem >= 2)) begin
                nm[c][nh[c]] = m[c][p] ^ m[c][p+1];
                nh[c] = nh[c] + 1;
                if (c + 1 < 2*N) begin
                  nm[c+1][nh[c+1]] = m[c][p] & m[c][p+1];
                  nh[c+1] = nh[c+1] + 1;
                end
                p = p + 2;
              end else if (rem >= 3) begin
                nm[c][nh[c]] = m[c][p] ^ m[c][p+1] ^ m[c][p+2];
                nh[c] = nh[c] + 1;
                if (c + 1 < 2*N) begin
                  nm[c+1][nh[c+1]] = (m[c][p] & m[c][p+1]) |
                                     (m[c][p] & m[c][p+2]) |
                                     (m[c][p+1] & m[c][p+2]);
                  nh[c+1] = nh[c+1] + 1;
                end
                p = p + 3;
              end
            end
          end
          for (int k = 0; k < N+2; k++) begin
            if (p + k < h[c]) begin
              nm[c][nh[c]] = m[c][p+k];
              nh[c] = nh[c] + 1;
            end
          end
        end
        m = nm;
        h = nh;
      end
    end
    for (int c = 0; c < 2*N; c++) begin
      r0[c] = m[c][0];
      r1[c] = m[c][1];
    end
    return {r1, r0};
  endfunction

  logic              adv_s;
  logic [N*N-1:0]    pp_s;
  logic [N*N-1:0]    pp_r;
  logic              sgn_r;
  logic [TAGW-1:0]   tag1_r;
  logic              v1_r;
  logic [4*N-1:0]    rows_s;
  logic [2*N-1:0]    row0_r;
  logic [2*N-1:0]    row1_r;
  logic [TAGW-1:0]   tag2_r;
  logic              v2_r;
  logic [2*N-1:0]    sum_s;
  logic              v3_r;

  // Global advance: the pipe moves whenever the output slot is free or draining
  always_comb begin
    adv_s    = (!v3_r) || out_ready;
    in_ready = adv_s;
  end

  // Partial-product generation; signed mode inverts bits where exactly one index is N-1
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp_s[i*N+j] = (A[i] & B[j]) ^ (sgn & ((i == N-1) != (j == N-1)));
      end
    end
  end

  // Stage-2 combinational Dadda reduction of the registered matrix
  always_comb begin
    rows_s = dadda_reduce(pp_r, sgn_r);
  end

  // Stage-3 carry-propagate add, truncated to the product width
  always_comb begin
    sum_s = row0_r + row1_r;
  end

  // S1 register: operands' partial products, mode and tag
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r   <= 1'b0;
      pp_r   <= '0;
      sgn_r  <= 1'b0;
      tag1_r <= '0;
    end else if (adv_s) begin
      v1_r   <= in_valid;
      pp_r   <= pp_s;
      sgn_r  <= sgn;
      tag1_r <= in_tag;
    end
  end

  // S2 register: the two reduced rows and the tag
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r   <= 1'b0;
      row0_r <= '0;
      row1_r <= '0;
      tag2_r <= '0;
    end else if (adv_s) begin
      v2_r   <= v1_r;
      row0_r <= rows_s[2*N-1:0];
      row1_r <= rows_s[4*N-1:2*N];
      tag2_r <= tag1_r;
    end
  end

  // S3 register: product and tag change only when a valid result is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r    <= 1'b0;
      y       <= '0;
      out_tag <= '0;
    end else if (adv_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        y       <= sum_s;
        out_tag <= tag2_r;
      end
    end
  end

  assign out_valid = v3_r;

endmodule

// File: tb/tb_dadda_mul_pipe.sv
// tb_dadda_mul_pipe: randomized self-checking bench for dadda_mul_pipe.
// Expected products come from wide integer arithmetic on sign-extended
// operands; a FIFO scoreboard enforces order, tag echo and no ghost results.
module tb_dadda_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [7:0]  A, B;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] y;

  logic        sw_valid;
  logic [3:0]  a4, b4;
  logic        s4, t4, rdy4, ov4, ot4;
  logic [7:0]  y4;
  logic [15:0] a16, b16;
  logic        s16, rdy16, ov16;
  logic [7:0]  t16, ot16;
  logic [31:0] y16;
  logic [31:0] a32, b32;
  logic        s32, rdy32, ov32;
  logic [7:0]  t32, ot32;
  logic [63:0] y32;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [63:0] exp_y_q[$];
  logic [7:0]  exp_tag_q[$];
  logic [63:0] q4_y[$], q16_y[$], q32_y[$];
  logic [7:0]  q4_t[$], q16_t[$], q32_t[$];
  logic [63:0] mon_ey;
  logic [7:0]  mon_et;

  dadda_mul_pipe #(.N(8), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sgn(sgn), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .out_tag(out_tag));

  dadda_mul_pipe #(.N(4), .TAGW(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4),
    .A(a4), .B(b4), .sgn(s4), .in_tag(t4), .out_valid(ov4),
    .out_ready(1'b1), .y(y4), .out_tag(ot4));

  dadda_mul_pipe #(.N(16), .TAGW(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16),
    .A(a16), .B(b16), .sgn(s16), .in_tag(t16), .out_valid(ov16),
    .out_ready(1'b1), .y(y16), .out_tag(ot16));

  dadda_mul_pipe #(.N(32), .TAGW(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32),
    .A(a32), .B(b32), .sgn(s32), .in_tag(t32), .out_valid(ov32),
    .out_ready(1'b1), .y(y32), .out_tag(ot32));

  // Cycle counter for throughput measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference product of two n-bit operands, reduced modulo 2^(2n)
  function automatic logic [63:0] ref_mul(input int n, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [127:0] av, bv, pr, mk;
    mk = (128'd1 << n) - 128'd1;
    av = {96'd0, a} & mk;
    bv = {96'd0, b} & mk;
    if (s && av[n-1]) av = av - (128'd1 << n);
    if (s && bv[n-1]) bv = bv - (128'd1 << n);
    pr = av * bv;
    pr = pr & ((128'd1 << (2*n)) - 128'd1);
    return pr[63:0];
  endfunction

  // Present one op (call just after a rising edge); record its expectation on acceptance
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] tag, input logic [63:0] ey);
    int w;
    A = a; B = b; sgn = s; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
    else begin
      exp_y_q.push_back(ey);
      exp_tag_q.push_back({4'd0, tag});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every accepted op of the main DUT has emerged
  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_y_q.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq(name, 64'(exp_y_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard for the main DUT: results in acceptance order, flushed by reset
  always @(negedge clk) begin
    if (rst) begin
      exp_y_q.delete();
      exp_tag_q.delete();
    end else if (out_valid && out_ready) begin
      if (exp_y_q.size() == 0) begin
        check_eq("sb_unexpected_result", {48'd0, y}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_ey = exp_y_q.pop_front();
        mon_et = exp_tag_q.pop_front();
        check_eq("sb_y", {48'd0, y}, mon_ey);
        check_eq("sb_tag", {60'd0, out_tag}, {56'd0, mon_et});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    logic [3:0]  rt;
    logic [63:0] ey;
    int          start;
    int          w;
    logic [15:0] idx;

    rst = 1'b1; in_valid = 1'b0; A = 8'd0; B = 8'd0; sgn = 1'b0; in_tag = 4'd0;
    out_ready = 1'b1; sw_valid = 1'b0;
    a4 = 4'd0; b4 = 4'd0; s4 = 1'b0; t4 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; s16 = 1'b0; t16 = 8'd0;
    a32 = 32'd0; b32 = 32'd0; s32 = 1'b0; t32 = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_y", {48'd0, y}, 64'd0);
    check_eq("rst_out_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single unsigned op and its latency: valid after the third edge incl. acceptance
    send(8'd255, 8'd255, 1'b0, 4'd3, 64'hFE01);
    repeat (2) begin
      @(negedge clk);
      check_eq("lat_not_yet", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    check_eq("lat_valid", {63'd0, out_valid}, 64'd1);
    check_eq("lat_y", {48'd0, y}, 64'hFE01);
    check_eq("lat_tag", {60'd0, out_tag}, 64'd3);
    @(posedge clk); #1;
    drain("drain_single");

    // Signed corners, back to back
    send(8'h80, 8'h80, 1'b1, 4'd1, 64'h4000);
    send(8'h80, 8'h7F, 1'b1, 4'd2, 64'hC080);
    send(8'hFF, 8'h01, 1'b1, 4'd3, 64'hFFFF);
    send(8'h00, 8'hB3, 1'b1, 4'd4, 64'h0000);
    drain("drain_corners");

    // Back-to-back random stream with per-op mode
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rt = 4'($urandom);
      ey = ref_mul(8, {24'd0, ra}, {24'd0, rb}, rs);
      send(ra, rb, rs, rt, ey);
    end
    check_eq("stream_cycles", 64'(cyc - start), 64'd20);
    drain("drain_stream");

    // Back-pressure: fill three stages, hold the consumer off for five cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rt = 4'(i + 9);
      ey = ref_mul(8, {24'd0, ra}, {24'd0, rb}, rs);
      send(ra, rb, rs, rt, ey);
    end
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check_eq("stall_out_valid", {63'd0, out_valid}, 64'd1);
      check_eq("stall_y", {48'd0, y}, exp_y_q[0]);
      check_eq("stall_tag", {60'd0, out_tag}, {56'd0, exp_tag_q[0]});
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("drain_backpressure");

    // Reset with two ops in flight: neither may ever appear
    send(8'd200, 8'd100, 1'b0, 4'd5, 64'd20000);
    send(8'd17, 8'd3, 1'b0, 4'd6, 64'd51);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_y", {48'd0, y}, 64'd0);
    check_eq("midrst_tag", {60'd0, out_tag}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("midrst_no_ghost", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    // Parameter sweep: N=4 exhaustive (both modes) then random; N=16/32 random, alternating mode
    for (int i = 0; i < 2004; i++) begin
      idx = 16'(i);
      sw_valid = (i < 2000);
      if (i < 512) begin
        a4 = idx[3:0]; b4 = idx[7:4]; s4 = idx[8];
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
      end
      t4 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); s16 = idx[0]; t16 = 8'($urandom);
      a32 = $urandom; b32 = $urandom; s32 = idx[0]; t32 = 8'($urandom);
      if (i % 50 == 0) begin
        a16 = 16'h8000; a32 = 32'h8000_0000;
      end
      if (i % 100 == 0) begin
        b16 = 16'h8000; b32 = 32'h8000_0000;
      end
      @(negedge clk);
      if (sw_valid && rdy4) begin
        q4_y.push_back(ref_mul(4, {28'd0, a4}, {28'd0, b4}, s4));
        q4_t.push_back({7'd0, t4});
      end
      if (sw_valid && rdy16) begin
        q16_y.push_back(ref_mul(16, {16'd0, a16}, {16'd0, b16}, s16));
        q16_t.push_back(t16);
      end
      if (sw_valid && rdy32) begin
        q32_y.push_back(ref_mul(32, a32, b32, s32));
        q32_t.push_back(t32);
      end
      if (ov4) begin
        if (q4_y.size() == 0) check_eq("n4_unexpected", {56'd0, y4}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          check_eq("n4_y", {56'd0, y4}, q4_y.pop_front());
          check_eq("n4_tag", {63'd0, ot4}, {56'd0, q4_t.pop_front()});
        end
      end
      if (ov16) begin
        if (q16_y.size() == 0) check_eq("n16_unexpected", {32'd0, y16}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          check_eq("n16_y", {32'd0, y16}, q16_y.pop_front());
          check_eq("n16_tag", {56'd0, ot16}, {56'd0, q16_t.pop_front()});
        end
      end
      if (ov32) begin
        if (q32_y.size() == 0) check_eq("n32_unexpected", y32, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          check_eq("n32_y", y32, q32_y.pop_front());
          check_eq("n32_tag", {56'd0, ot32}, {56'd0, q32_t.pop_front()});
        end
      end
      @(posedge clk); #1;
    end
    check_eq("n4_drained", 64'(q4_y.size()), 64'd0);
    check_eq("n16_drained", 64'(q16_y.size()), 64'd0);
    check_eq("n32_drained", 64'(q32_y.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
